// File: rtl/btn_led_scheduler.sv
// Four debounced push buttons compete for a shared LED bank; each grant shows a one-hot pattern, then a blank gap.
// Arbitration is round-robin by default; define BTN_SCHED_FIXED_PRIO_EN for fixed priority (BTN[0] highest).
module btn_led_scheduler #(
   parameter int DEBOUNCE_CYCLES = 256,
   parameter int HOLD_CYCLES     = 1000,
   parameter int GAP_CYCLES      = 100
) (
   input  logic       CLK_IN,
   input  logic       CPU_RESETN,
   input  logic [3:0] BTN,
   output logic [3:0] leds,
   output logic       busy,
   output logic [1:0] grant_id,
   output logic [3:0] missed
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [19:0] HOLD_LAST = 20'(HOLD_CYCLES - 1);
   localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);

   logic [3:0]  btn_sync_p0;
   logic [3:0]  btn_sync_p1;
   logic [3:0]  btn_acc;
   logic [3:0]  btn_acc_q;
   logic [15:0] db_cnt [4];
   logic [3:0]  press;
   logic [3:0]  pending;
   logic [3:0]  grant_clr;
   logic [1:0]  winner;
   logic [19:0] tmr;
   state_t      state;

`ifdef BTN_SCHED_FIXED_PRIO_EN
   function automatic logic [1:0] pick(input logic [3:0] req);
      pick = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) pick = 2'(k);
      end
   endfunction

   assign winner = pick(pending);
`else
   logic [1:0] last_grant;

   // Walk from farthest to nearest so the requester right after last_grant wins.
   function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] last);
      logic [1:0] idx;
      pick = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) pick = idx;
      end
   endfunction

   assign winner = pick(pending, last_grant);
`endif

   // Stage p0/p1: two-flop synchronizer on the raw buttons
   always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
      if (CPU_RESETN) begin
         btn_sync_p0 <= '0;
         btn_sync_p1 <= '0;
      end else begin
         btn_sync_p0 <= BTN;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // Debounce: counter runs only while the synchronized level differs from the accepted one
   always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
      if (CPU_RESETN) begin
         btn_acc   <= '0;
         btn_acc_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         btn_acc_q <= btn_acc;
         for (int i = 0; i < 4; i++) begin
            if (btn_sync_p1[i] == btn_acc[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_acc[i] <= btn_sync_p1[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign press     = btn_acc & ~btn_acc_q;
   assign grant_clr = (state == IDLE && pending != 4'd0) ? (4'b0001 << winner) : 4'd0;

   // A new press beats a same-cycle grant clear and is not counted as missed.
   always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
      if (CPU_RESETN) begin
         pending <= '0;
         missed  <= '0;
      end else begin
         pending <= (pending & ~grant_clr) | press;
         missed  <= missed | (press & pending & ~grant_clr);
      end
   end

   always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
      if (CPU_RESETN) begin
         state    <= IDLE;
         leds     <= '0;
         grant_id <= '0;
         tmr      <= '0;
`ifndef BTN_SCHED_FIXED_PRIO_EN
         last_grant <= 2'd3;
`endif
      end else begin
         case (state)
            IDLE: begin
               leds <= '0;
               if (pending != 4'd0) begin
                  state    <= SHOW;
                  grant_id <= winner;
                  leds     <= 4'b0001 << winner;
                  tmr      <= HOLD_LAST;
`ifndef BTN_SCHED_FIXED_PRIO_EN
                  last_grant <= winner;
`endif
               end
            end
            SHOW: begin
               if (tmr == 20'd0) begin
                  state <= GAP;
                  leds  <= '0;
                  tmr   <= GAP_LAST;
               end else begin
                  tmr <= tmr - 20'd1;
               end
            end
            GAP: begin
               leds <= '0;
               if (tmr == 20'd0) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr - 20'd1;
               end
            end
            default: begin
               state <= IDLE;
               leds  <= '0;
               tmr   <= '0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_btn_led_scheduler.sv
// Scoreboard bench for btn_led_scheduler (DEBOUNCE=4, HOLD=8, GAP=2): directed presses push expected grants,
// a monitor pops them when the LED bank lights and checks pattern, hold length and gap length.
module tb_btn_led_scheduler;

   localparam int DB  = 4;
   localparam int HLD = 8;
   localparam int GP  = 2;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] leds;
   logic       busy;
   logic [1:0] grant_id;
   logic [3:0] missed;

   int vectors;
   int errors;
   int cyc;
   int exp_q[$];
   int starts[$];

   btn_led_scheduler #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES    (HLD),
      .GAP_CYCLES     (GP)
   ) dut (
      .CLK_IN    (clk),
      .CPU_RESETN(rst),
      .BTN       (btn),
      .leds      (leds),
      .busy      (busy),
      .grant_id  (grant_id),
      .missed    (missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected grant is consumed each time the LED bank lights up
   initial begin : monitor
      int hold;
      int gap;
      int e;
      logic [3:0] pat;
      forever begin
         @(negedge clk);
         if (!rst && leds != 4'd0) begin
            starts.push_back(cyc);
            pat = leds;
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", int'(leds), 0);
            end else begin
               e = exp_q.pop_front();
               chk("grant_id", int'(grant_id), e);
               chk("leds_onehot", int'(leds), 1 << e);
               chk("busy_show", int'(busy), 1);
            end
            hold = 1;
            @(negedge clk);
            while (!rst && leds == pat && hold < 50) begin
               hold++;
               @(negedge clk);
            end
            if (!rst) begin
               chk("hold_len", hold, HLD);
               gap = 0;
               while (!rst && busy && leds == 4'd0 && gap < 50) begin
                  gap++;
                  @(negedge clk);
               end
               if (!rst) begin
                  chk("gap_len", gap, GP);
                  chk("idle_after_gap", int'(busy), 0);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      btn = 4'd0;
      rst = 1'b1;
      #1;
      chk("rst_leds", int'(leds), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_missed", int'(missed), 0);
      chk("rst_pending", int'(dut.pending), 0);
      repeat (3) @(negedge clk);
      chk("rst_grant_id", int'(grant_id), 0);
      exp_q.delete();
      starts.delete();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
      repeat (30) @(negedge clk);
   endtask

   task automatic check_spacing(input int want_grants);
      chk("grant_count", starts.size(), want_grants);
      for (int k = 1; k < starts.size(); k++)
         chk("grant_spacing", starts[k] - starts[k-1], HLD + GP + 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      vectors = 0;
      errors  = 0;
      btn     = 4'd0;
      rst     = 1'b1;
      repeat (2) @(negedge clk);
      do_reset();

      // Clean BTN[2] press held 20 cycles
      exp_q.push_back(2);
      btn[2] = 1'b1;
      repeat (20) @(negedge clk);
      btn[2] = 1'b0;
      drain("drain_clean_press");
      chk("missed_clean", int'(missed), 0);

      // Bouncing BTN[1]: toggles every 2 cycles, then stable high
      exp_q.push_back(1);
      for (int c = 0; c < 10; c++) begin
         btn[1] = ((c / 2) % 2 == 0);
         @(negedge clk);
      end
      btn[1] = 1'b1;
      repeat (20) @(negedge clk);
      btn[1] = 1'b0;
      drain("drain_bounce");
      chk("missed_bounce", int'(missed), 0);

      // All four together from reset, plus a second BTN[0] press during grant 1
      do_reset();
`ifdef BTN_SCHED_FIXED_PRIO_EN
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      exp_q.push_back(2); exp_q.push_back(3);
`else
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0);
`endif
      for (int c = 0; c < 40; c++) begin
         if (c < 6) btn = 4'hF;
         else if (c >= 18 && c < 24) btn = 4'h1;
         else btn = 4'h0;
         @(negedge clk);
      end
      drain("drain_all_four");
      check_spacing(5);
      chk("missed_all_four", int'(missed), 0);

      // BTN[3] pressed twice while queued behind 0,1,2
      do_reset();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
      for (int c = 0; c < 30; c++) begin
         btn[2:0] = (c < 20) ? 3'b111 : 3'b000;
         btn[3]   = (c < 5) || (c >= 10 && c < 15);
         @(negedge clk);
      end
      drain("drain_missed");
      chk("missed_btn3", int'(missed), 8);

      // Round-robin wrap: grant 3 first, then 0 and 3 pending together
      do_reset();
      exp_q.push_back(3);
      btn = 4'b1000;
      repeat (8) @(negedge clk);
      btn = 4'b0000;
      drain("drain_wrap_first");
      exp_q.push_back(0); exp_q.push_back(3);
      btn = 4'b1001;
      repeat (8) @(negedge clk);
      btn = 4'b0000;
      drain("drain_wrap");
      chk("missed_wrap", int'(missed), 0);

      // Reset pulse in the middle of a SHOW
      do_reset();
      exp_q.push_back(1);
      btn = 4'b0010;
      n = 0;
      while (leds == 4'd0 && n < 50) begin
         @(negedge clk);
         n++;
         if (n == 7) btn = 4'b0000;
      end
      btn = 4'b0000;
      chk("show_reached", int'(leds), 2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midshow_leds", int'(leds), 0);
      chk("midshow_busy", int'(busy), 0);
      chk("midshow_pending", int'(dut.pending), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (40) @(negedge clk);
      chk("no_grant_after_reset", int'(busy), 0);
      chk("leds_after_reset", int'(leds), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/btn_led_scheduler.md
BTN_LED_SCHEDULER -- requirements
Module: btn_led_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 256: consecutive stable cycles before a button level is accepted (range 2..65535).
REQ-002 Parameter HOLD_CYCLES, default 1000: cycles a granted LED pattern is displayed (range 1..2^20).
REQ-003 Parameter GAP_CYCLES, default 100: blank cycles after each display (range 1..2^20).
REQ-004 Port CLK_IN, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port CPU_RESETN, input, 1: asynchronous, active-high reset (1 = reset asserted).
REQ-006 Port BTN, input, 4: raw asynchronous push buttons, requester i = BTN[i].
REQ-007 Port leds, output, 4: LED bank, the shared resource.
REQ-008 Port busy, output, 1: high whenever FSM is not IDLE.
REQ-009 Port grant_id, output, 2: index of the requester currently or last granted.
REQ-010 Port missed, output, 4: sticky flag per requester, press lost while already pending.

Function
REQ-011 Each BTN[i] SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Per-button debounce counter SHALL restart on any change of synchronized level; accepted level SHALL update when level held DEBOUNCE_CYCLES consecutive cycles.
REQ-013 Rising edge of accepted level SHALL produce a one-cycle press pulse; falling edges produce nothing.
REQ-014 Press pulse SHALL set pending[i] on the next edge; press while pending[i]=1 SHALL set missed[i] and leave pending[i]=1.
REQ-015 Press on requester i in the same cycle its pending[i] is cleared by grant SHALL leave pending[i]=1 (set wins), missed[i] unchanged.
REQ-016 FSM states: IDLE, SHOW, GAP; 2-bit encoding, unused codes return to IDLE.
REQ-017 IDLE with pending!=0: at that edge go SHOW, load grant_id with winner, clear pending[winner], leds <= one-hot(winner), load hold counter.
REQ-018 Round-robin: search order starts at (last grant + 1) mod 4, wraps 3->0; last grant updates only on a grant.
REQ-019 SHOW SHALL last exactly HOLD_CYCLES cycles, then go GAP with leds <= 0.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then go IDLE; arbitration occurs only in IDLE, so one IDLE cycle separates back-to-back grants.
REQ-021 Presses arriving during SHOW/GAP SHALL be queued in pending, not dropped (except per REQ-014).
REQ-022 leds SHALL be registered and 0 in IDLE and GAP; busy = (state != IDLE), combinational from state register.

Reset
REQ-023 On CPU_RESETN=1, immediately: state IDLE, leds 0, busy 0, grant_id 0, last grant 3, pending 0, missed 0, synchronizers 0, accepted levels 0, all counters 0.
REQ-024 Reset mid-SHOW/GAP SHALL abort the sequence with no residual grant after release.
REQ-025 A button held through reset release SHALL yield exactly one press after DEBOUNCE_CYCLES.

Configuration
REQ-026 Macro BTN_SCHED_FIXED_PRIO_EN defined: arbitration is fixed priority, BTN[0] highest, BTN[3] lowest; last-grant state unused.
REQ-027 Macro BTN_SCHED_FIXED_PRIO_EN undefined (default): round-robin per REQ-018.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, GAP_CYCLES=2 unless noted)
REQ-028 BTN[2] clean press held 20 cycles -> single grant, grant_id=2, leds=4'b0100 for exactly 8 cycles, then 0 for 2 cycles, busy low after.
REQ-029 BTN[1] bouncing (toggle every 2 cycles for 10 cycles, then stable high) -> exactly one grant, missed=0.
REQ-030 BTN[0..3] pressed simultaneously from reset -> grants in order 0,1,2,3, each separated by 2 gap + 1 idle cycles; with BTN_SCHED_FIXED_PRIO_EN same order, and a second BTN[0] press during grant 1 is served before 2.
REQ-031 BTN[3] pressed twice during another requester's SHOW -> one grant to 3, missed=4'b1000.
REQ-032 CPU_RESETN pulsed mid-SHOW -> leds=0, busy=0, pending=0 in the same cycle; no grant follows with BTN low.
REQ-033 Round-robin wrap: grant 3 last, then BTN[0] and BTN[3] pending -> grant_id=0 first.
